nubus_master_sched: RTL and testbench
=====================================

# nubus_master_sched

Two-requester scheduler in front of the NuBus master port of the `nubus` core. It shares that single master transaction port between the local CPU (requester 0) and a DMA engine (requester 1). It uses round-robin arbitration, honours locked sequences and applies a response timeout. Each requester sees a simple valid/ready memory interface. The scheduler issues one transaction at a time to the core and returns read data, or an error on timeout.

## Interface
Parameters:
- `TIMEOUT`, 255: maximum cycles `mst_valid` is held without `mst_ready` before the transaction is aborted. Legal range 1..(2^TO_W−1).
- `TO_W`, 8: width of the timeout counter.
- `ERR_DATA`, 32'hFFFF_FFFF: read data returned on a timeout.

Ports:
- `nub_clkn` in 1: NuBus clock. All flops update on the falling edge of `nub_clkn` (the NuBus sampling edge).
- `nub_resetn` in 1: reset, asynchronous, active-low.
- `r0_valid`, `r1_valid` in 1: request valid. Held, with payload stable, until the matching `rX_ready`.
- `r0_addr`, `r1_addr` in 32: byte address.
- `r0_wdata`, `r1_wdata` in 32: write data.
- `r0_wstrb`, `r1_wstrb` in 4: byte strobes. 0 means read.
- `r0_lock`, `r1_lock` in 1: hold the grant across transactions.
- `r0_ready`, `r1_ready` out 1: one-cycle completion pulse.
- `r0_err`, `r1_err` out 1: completion was a timeout. Valid with `rX_ready`.
- `r_rdata` out 32: shared response data. Valid with either `rX_ready`.
- `mst_valid` out 1: transaction request to the core.
- `mst_addr` out 32, `mst_wdata` out 32, `mst_wstrb` out 4: latched payload.
- `mst_lock` out 1: latched lock of the current grantee.
- `mst_ready` in 1: core completion.
- `mst_rdata` in 32: core read data.
- `gnt` out 1: index of the current or last grantee.

## Operation
- The FSM has three states: IDLE, ISSUE, DONE.
- **IDLE.** Pick a requester:
  - If `lock_own` is set, only requester `gnt` is eligible.
  - Otherwise, when both are valid, grant the one that is not `gnt`.
  - When only one is valid, grant it.
  - On a grant: latch addr/wdata/wstrb/lock into the `mst_*` registers, update `gnt`, clear the counter, go to ISSUE.
  - With no eligible request, stay in IDLE.
- **ISSUE.** `mst_valid`=1.
  - If `mst_ready` is sampled: capture `mst_rdata` into `r_rdata`, set err=0, go to DONE.
  - Else if counter==TIMEOUT−1: `r_rdata`=ERR_DATA, err=1, go to DONE.
  - Else increment the counter.
- **DONE.** `rX_ready`=1 for the grantee only, with `rX_err` as captured.
  - Set `lock_own` ← latched lock.
  - Go to IDLE.
- **Lock release.** In IDLE with `lock_own` set and `r[gnt]_lock`=0, clear `lock_own`. Arbitration in that same IDLE cycle uses the cleared value.
- **Reads vs writes.** Data capture is identical for both; for writes `r_rdata` content is don't-care.
- **Error path.** A timeout on a locked transaction still sets `lock_own`, so the owner's retry keeps its priority.

## Timing
- **Reset values.** All outputs are 0, except `gnt`=1 so that requester 0 wins the first tie. State IDLE, `lock_own`=0, counter 0.
- **Reset mid-transaction** drops `mst_valid` immediately (asynchronously). No `rX_ready` is produced.
- **Issue latency.** A request sampled in IDLE at edge k gives `mst_valid`=1 from edge k to edge k+1 onward.
- **Completion latency.** `mst_ready` sampled at edge m gives `mst_valid`=0 and `rX_ready`=1 in the cycle after m, then IDLE at m+1. The earliest next issue is edge m+2.
- **Throughput.** At most one transaction per 3 cycles plus core latency.
- **Timeout.** With no `mst_ready`, `mst_valid` stays high exactly TIMEOUT cycles, then DONE with err=1.
- **Simultaneous ready and timeout.** `mst_ready` sampled on the same edge as counter==TIMEOUT−1 counts as success, err=0.
- **Payload stability.** `mst_addr/wdata/wstrb/lock` are stable from the ISSUE entry edge until the next grant.
- **Ignored inputs.** `rX_valid` is ignored outside IDLE. Requester payload changes after the grant have no effect.

## Structure
- Package `nubus_sched_pkg` holds:
  - the state enum (`S_IDLE`, `S_ISSUE`, `S_DONE`);
  - the `TIMEOUT` and `ERR_DATA` defaults.
- One sub-module, `nubus_rr_pick`, is combinational. It takes the two valids, `gnt`, and `lock_own`, and returns the grant and the grant index.
- FSM, counter and payload registers live in `nubus_master_sched`.

## Test plan
- **Single read.** r0 read of 0xF5000010 with the core answering 0xDEADBEEF after 3 cycles. Required: `mst_valid` high 3 cycles, `mst_addr`=0xF5000010, `mst_wstrb`=0; then `r0_ready` pulses once with `r_rdata`=0xDEADBEEF and `r0_err`=0.
- **Round robin.** r0 and r1 both valid continuously for 4 transactions. Required grant order 0,1,0,1; `r1_ready` never coincides with `r0_ready`.
- **Lock.** r1 issues 3 writes with `r1_lock`=1 while r0 stays valid. Required: all 3 r1 writes complete before r0 is granted; r0 is granted in the IDLE cycle after `r1_lock` drops.
- **Timeout.** TIMEOUT=4 and the core never answers. Required: `mst_valid` high exactly 4 cycles, then `rX_ready`=1 with err=1 and `r_rdata`=0xFFFFFFFF.
- **Ready and timeout on the same edge.** `mst_ready` arrives on the 4th cycle with TIMEOUT=4. Required: err=0 and `r_rdata`=core data.
- **Reset mid-ISSUE.** Assert `nub_resetn`=0 while in ISSUE. Required: `mst_valid`=0 without a clock edge, no `rX_ready`; after release, the next tie is granted to r0.

Source files
------------

// File: rtl/nubus_sched_pkg.sv
// Shared types and defaults for the NuBus master-port scheduler.
package nubus_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DONE  = 2'd2
    } sched_state_t;

    // Default response timeout in cycles, and the read data returned on timeout.
    localparam int unsigned DEF_TIMEOUT  = 255;
    localparam logic [31:0] DEF_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/nubus_master_sched_if.sv
// Bus bundle between the two requesters, the scheduler and the nubus core.
//
// Handshake: a requester raises rX_valid with a stable payload and holds it
// until the scheduler pulses rX_ready for one cycle; rX_err and r_rdata are
// only meaningful in that cycle. Towards the core, mst_valid is held with a
// stable payload until the core returns mst_ready, or until the scheduler
// gives up after TIMEOUT cycles.
interface nubus_master_sched_if;
    logic        r0_valid, r1_valid;
    logic [31:0] r0_addr, r1_addr;
    logic [31:0] r0_wdata, r1_wdata;
    logic [3:0]  r0_wstrb, r1_wstrb;
    logic        r0_lock, r1_lock;
    logic        r0_ready, r1_ready;
    logic        r0_err, r1_err;
    logic [31:0] r_rdata;
    logic        mst_valid;
    logic [31:0] mst_addr, mst_wdata;
    logic [3:0]  mst_wstrb;
    logic        mst_lock;
    logic        mst_ready;
    logic [31:0] mst_rdata;
    logic        gnt;

    // Scheduler side.
    modport master (
        input  r0_valid, r1_valid, r0_addr, r1_addr, r0_wdata, r1_wdata,
               r0_wstrb, r1_wstrb, r0_lock, r1_lock, mst_ready, mst_rdata,
        output r0_ready, r1_ready, r0_err, r1_err, r_rdata, mst_valid,
               mst_addr, mst_wdata, mst_wstrb, mst_lock, gnt
    );

    // Requesters plus core side.
    modport slave (
        output r0_valid, r1_valid, r0_addr, r1_addr, r0_wdata, r1_wdata,
               r0_wstrb, r1_wstrb, r0_lock, r1_lock, mst_ready, mst_rdata,
        input  r0_ready, r1_ready, r0_err, r1_err, r_rdata, mst_valid,
               mst_addr, mst_wdata, mst_wstrb, mst_lock, gnt
    );
endinterface

// File: rtl/nubus_rr_pick.sv
// Combinational two-way round-robin pick with lock override.
module nubus_rr_pick (
    input  logic v0,
    input  logic v1,
    input  logic gnt,
    input  logic lock_own,
    output logic grant,
    output logic idx
);
    // A held lock restricts eligibility to the last grantee; otherwise a tie
    // goes to whoever was not granted last.
    always_comb begin
        grant = 1'b0;
        idx   = gnt;
        if (lock_own) begin
            grant = gnt ? v1 : v0;
            idx   = gnt;
        end else if (v0 && v1) begin
            grant = 1'b1;
            idx   = ~gnt;
        end else if (v0) begin
            grant = 1'b1;
            idx   = 1'b0;
        end else if (v1) begin
            grant = 1'b1;
            idx   = 1'b1;
        end
    end
endmodule

// File: rtl/nubus_master_sched.sv
// Shares the nubus master transaction port between CPU (0) and DMA (1).
// All state advances on the falling edge of nub_clkn.
module nubus_master_sched
    import nubus_sched_pkg::*;
#(
    parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
    parameter int unsigned TO_W     = 8,
    parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
    input  logic                  nub_clkn,
    input  logic                  nub_resetn,
    nubus_master_sched_if.master  bus,
    output sched_state_t          state_dbg
);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT - 1);

    sched_state_t    state_q, state_d;
    logic [TO_W-1:0] cnt_q;
    logic            gnt_q, lock_own_q, err_q;
    logic [31:0]     rdata_q, addr_q, wdata_q;
    logic [3:0]      wstrb_q;
    logic            lock_q;
    logic            cur_lock, lock_eff, pick_grant, pick_idx;

    // The lock stays owned only while the owner keeps its lock input high;
    // a drop is seen in the same IDLE cycle that arbitrates.
    assign cur_lock = gnt_q ? bus.r1_lock : bus.r0_lock;
    assign lock_eff = lock_own_q && cur_lock;

    nubus_rr_pick u_pick (
        .v0       (bus.r0_valid),
        .v1       (bus.r1_valid),
        .gnt      (gnt_q),
        .lock_own (lock_eff),
        .grant    (pick_grant),
        .idx      (pick_idx)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (pick_grant) state_d = S_ISSUE;
            S_ISSUE: if (bus.mst_ready || cnt_q == CNT_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Grant, payload latch, timeout counter and response capture.
    always_ff @(negedge nub_clkn or negedge nub_resetn) begin
        if (!nub_resetn) begin
            gnt_q      <= 1'b1;
            lock_own_q <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            lock_q     <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (lock_own_q && !cur_lock) lock_own_q <= 1'b0;
                    if (pick_grant) begin
                        gnt_q   <= pick_idx;
                        addr_q  <= pick_idx ? bus.r1_addr  : bus.r0_addr;
                        wdata_q <= pick_idx ? bus.r1_wdata : bus.r0_wdata;
                        wstrb_q <= pick_idx ? bus.r1_wstrb : bus.r0_wstrb;
                        lock_q  <= pick_idx ? bus.r1_lock  : bus.r0_lock;
                        cnt_q   <= '0;
                    end
                end
                S_ISSUE: begin
                    if (bus.mst_ready) begin
                        rdata_q <= bus.mst_rdata;
                        err_q   <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= ERR_DATA;
                        err_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: lock_own_q <= lock_q;
                default: ;
            endcase
        end
    end

    assign bus.mst_valid = (state_q == S_ISSUE);
    assign bus.mst_addr  = addr_q;
    assign bus.mst_wdata = wdata_q;
    assign bus.mst_wstrb = wstrb_q;
    assign bus.mst_lock  = lock_q;
    assign bus.r0_ready  = (state_q == S_DONE) && !gnt_q;
    assign bus.r1_ready  = (state_q == S_DONE) && gnt_q;
    assign bus.r0_err    = bus.r0_ready && err_q;
    assign bus.r1_err    = bus.r1_ready && err_q;
    assign bus.r_rdata   = rdata_q;
    assign bus.gnt       = gnt_q;
    assign state_dbg     = state_q;
endmodule

// File: tb/tb_nubus_master_sched.sv
// Bench for nubus_master_sched with a small core model and a response scoreboard.
module tb_nubus_master_sched;
    import nubus_sched_pkg::*;

    localparam logic [31:0] K = 32'hA5A5_5A5A;

    logic         nub_clkn;
    logic         nub_resetn;
    sched_state_t state_dbg;
    nubus_master_sched_if bus ();

    int checks   = 0;
    int failures = 0;

    // Scoreboard entry: {check_data, err, idx, data}
    logic [34:0] exp_q[$];

    // Core model controls
    int          core_cnt;
    int          core_lat = 1;
    logic        core_en = 1'b1;
    logic        core_fixed_en = 1'b0;
    logic [31:0] core_fixed = '0;

    nubus_master_sched #(.TIMEOUT(4), .TO_W(8), .ERR_DATA(32'hFFFF_FFFF)) dut (
        .nub_clkn   (nub_clkn),
        .nub_resetn (nub_resetn),
        .bus        (bus.master),
        .state_dbg  (state_dbg)
    );

    // Clock / reset
    initial nub_clkn = 1'b1;
    always #5 nub_clkn = ~nub_clkn;

    // Core model: answers core_lat cycles after mst_valid rises.
    always @(posedge nub_clkn) begin
        if (!nub_resetn || !bus.mst_valid) begin
            core_cnt      = 0;
            bus.mst_ready = 1'b0;
            bus.mst_rdata = '0;
        end else begin
            core_cnt      = core_cnt + 1;
            bus.mst_ready = core_en && (core_cnt == core_lat);
            bus.mst_rdata = core_fixed_en ? core_fixed : (bus.mst_addr ^ K);
        end
    end

    // Scoreboard: pop and compare on every completion pulse.
    always @(posedge nub_clkn) begin
        logic [34:0] e;
        logic        oidx, oerr;
        if (nub_resetn && (bus.r0_ready || bus.r1_ready)) begin
            checks++;
            if (bus.r0_ready && bus.r1_ready) begin
                failures++;
                $display("FAIL both_ready r0_ready=1 r1_ready=1 required one");
            end
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_ready r0=%0b r1=%0b required none", bus.r0_ready, bus.r1_ready);
            end else begin
                e    = exp_q.pop_front();
                oidx = bus.r1_ready;
                oerr = oidx ? bus.r1_err : bus.r0_err;
                checks++;
                if (oidx !== e[32]) begin
                    failures++;
                    $display("FAIL sb_idx got=%0d required=%0d", oidx, e[32]);
                end
                checks++;
                if (oerr !== e[33]) begin
                    failures++;
                    $display("FAIL sb_err got=%0b required=%0b", oerr, e[33]);
                end
                if (e[34]) begin
                    checks++;
                    if (bus.r_rdata !== e[31:0]) begin
                        failures++;
                        $display("FAIL sb_rdata got=%h required=%h", bus.r_rdata, e[31:0]);
                    end
                end
            end
        end
    end

    function automatic void exp_push(input logic chk, input logic err, input logic idx, input logic [31:0] d);
        exp_q.push_back({chk, err, idx, d});
    endfunction

    task automatic test_reset();
        nub_resetn = 1'b0;
        bus.r0_valid = 0; bus.r1_valid = 0;
        bus.r0_addr = 0; bus.r1_addr = 0; bus.r0_wdata = 0; bus.r1_wdata = 0;
        bus.r0_wstrb = 0; bus.r1_wstrb = 0; bus.r0_lock = 0; bus.r1_lock = 0;
        repeat (3) @(posedge nub_clkn);
        checks++; if (bus.mst_valid !== 1'b0) begin failures++; $display("FAIL rst_mst_valid got=%b required=0", bus.mst_valid); end
        checks++; if (bus.gnt !== 1'b1) begin failures++; $display("FAIL rst_gnt got=%b required=1", bus.gnt); end
        checks++; if ({bus.r0_ready, bus.r1_ready, bus.r0_err, bus.r1_err} !== 4'b0) begin failures++; $display("FAIL rst_ready_err got=%b required=0000", {bus.r0_ready, bus.r1_ready, bus.r0_err, bus.r1_err}); end
        checks++; if (bus.r_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h required=0", bus.r_rdata); end
        checks++; if ({bus.mst_addr, bus.mst_wdata, bus.mst_wstrb, bus.mst_lock} !== 69'h0) begin failures++; $display("FAIL rst_payload got=%h required=0", {bus.mst_addr, bus.mst_wdata, bus.mst_wstrb, bus.mst_lock}); end
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL rst_state got=%0d required=%0d", state_dbg, S_IDLE); end
        nub_resetn = 1'b1;
        @(posedge nub_clkn);
    endtask

    task automatic test_single_read();
        int vcyc = 0, rdy = 0;
        logic [31:0] seen_addr = '0;
        logic [3:0]  seen_strb = 4'hF;
        core_fixed_en = 1; core_fixed = 32'hDEAD_BEEF; core_lat = 3; core_en = 1;
        exp_push(1, 0, 0, 32'hDEAD_BEEF);
        bus.r0_addr = 32'hF500_0010; bus.r0_wstrb = 0; bus.r0_lock = 0; bus.r0_valid = 1;
        for (int c = 0; c < 14; c++) begin
            @(posedge nub_clkn);
            if (bus.mst_valid) begin vcyc++; seen_addr = bus.mst_addr; seen_strb = bus.mst_wstrb; end
            if (bus.r0_ready) begin rdy++; bus.r0_valid = 0; end
        end
        core_fixed_en = 0;
        checks++; if (vcyc !== 3) begin failures++; $display("FAIL read_valid_cycles got=%0d required=3", vcyc); end
        checks++; if (seen_addr !== 32'hF500_0010) begin failures++; $display("FAIL read_addr got=%h required=f5000010", seen_addr); end
        checks++; if (seen_strb !== 4'h0) begin failures++; $display("FAIL read_wstrb got=%h required=0", seen_strb); end
        checks++; if (rdy !== 1) begin failures++; $display("FAIL read_ready_pulses got=%0d required=1", rdy); end
    endtask

    task automatic test_round_robin();
        int n0 = 0, n1 = 0;
        logic overlap = 0;
        nub_resetn = 0; @(posedge nub_clkn); nub_resetn = 1; @(posedge nub_clkn);
        core_lat = 1; core_en = 1;
        exp_push(1, 0, 0, 32'h0000_A000 ^ K);
        exp_push(1, 0, 1, 32'h0000_B000 ^ K);
        exp_push(1, 0, 0, 32'h0000_A004 ^ K);
        exp_push(1, 0, 1, 32'h0000_B004 ^ K);
        bus.r0_addr = 32'h0000_A000; bus.r0_wstrb = 0; bus.r0_lock = 0;
        bus.r1_addr = 32'h0000_B000; bus.r1_wstrb = 0; bus.r1_lock = 0;
        bus.r0_valid = 1; bus.r1_valid = 1;
        for (int c = 0; c < 30; c++) begin
            @(posedge nub_clkn);
            if (bus.r0_ready && bus.r1_ready) overlap = 1;
            if (bus.r0_ready) begin n0++; bus.r0_addr = bus.r0_addr + 4; if (n0 == 2) bus.r0_valid = 0; end
            if (bus.r1_ready) begin n1++; bus.r1_addr = bus.r1_addr + 4; if (n1 == 2) bus.r1_valid = 0; end
        end
        checks++; if (n0 + n1 !== 4) begin failures++; $display("FAIL rr_completions got=%0d required=4", n0 + n1); end
        checks++; if (overlap !== 1'b0) begin failures++; $display("FAIL rr_overlap got=%b required=0", overlap); end
    endtask

    task automatic test_lock();
        int n1 = 0, t3 = -1, tg = -1;
        logic lock_seen = 0;
        core_lat = 1; core_en = 1;
        exp_push(0, 0, 1, 32'h0);
        exp_push(0, 0, 1, 32'h0);
        exp_push(0, 0, 1, 32'h0);
        exp_push(1, 0, 0, 32'h0000_D000 ^ K);
        bus.r1_addr = 32'h0000_C000; bus.r1_wdata = 32'h1234_0000; bus.r1_wstrb = 4'hF;
        bus.r1_lock = 1; bus.r1_valid = 1;
        @(posedge nub_clkn);
        bus.r0_addr = 32'h0000_D000; bus.r0_wstrb = 0; bus.r0_lock = 0; bus.r0_valid = 1;
        for (int c = 0; c < 30; c++) begin
            @(posedge nub_clkn);
            if (bus.mst_valid && bus.gnt && bus.mst_lock) lock_seen = 1;
            if (bus.mst_valid && !bus.gnt && tg < 0) tg = c;
            if (bus.r1_ready) begin
                n1++;
                bus.r1_addr = bus.r1_addr + 4; bus.r1_wdata = bus.r1_wdata + 1;
                if (n1 == 3) begin t3 = c; bus.r1_valid = 0; bus.r1_lock = 0; end
            end
            if (bus.r0_ready) bus.r0_valid = 0;
        end
        checks++; if (lock_seen !== 1'b1) begin failures++; $display("FAIL lock_mst_lock got=%b required=1", lock_seen); end
        checks++; if (n1 !== 3) begin failures++; $display("FAIL lock_r1_count got=%0d required=3", n1); end
        checks++; if (tg - t3 !== 2) begin failures++; $display("FAIL lock_r0_grant_delay got=%0d required=2", tg - t3); end
    endtask

    task automatic test_timeout();
        int vcyc = 0, rdy = 0;
        core_en = 0;
        exp_push(1, 1, 1, 32'hFFFF_FFFF);
        bus.r1_addr = 32'h0000_E000; bus.r1_wstrb = 0; bus.r1_lock = 0; bus.r1_valid = 1;
        for (int c = 0; c < 14; c++) begin
            @(posedge nub_clkn);
            if (bus.mst_valid) vcyc++;
            if (bus.r1_ready) begin rdy++; bus.r1_valid = 0; end
        end
        core_en = 1;
        checks++; if (vcyc !== 4) begin failures++; $display("FAIL timeout_valid_cycles got=%0d required=4", vcyc); end
        checks++; if (rdy !== 1) begin failures++; $display("FAIL timeout_ready_pulses got=%0d required=1", rdy); end
    endtask

    task automatic test_ready_at_timeout();
        int vcyc = 0;
        core_en = 1; core_lat = 4;
        exp_push(1, 0, 0, 32'h0000_F000 ^ K);
        bus.r0_addr = 32'h0000_F000; bus.r0_wstrb = 0; bus.r0_lock = 0; bus.r0_valid = 1;
        for (int c = 0; c < 14; c++) begin
            @(posedge nub_clkn);
            if (bus.mst_valid) vcyc++;
            if (bus.r0_ready) bus.r0_valid = 0;
        end
        core_lat = 1;
        checks++; if (vcyc !== 4) begin failures++; $display("FAIL edge_valid_cycles got=%0d required=4", vcyc); end
    endtask

    task automatic test_reset_mid_issue();
        logic seen = 0;
        int   rdy = 0, first_gnt = -1;
        core_en = 0;
        bus.r0_addr = 32'h0000_0100; bus.r0_wstrb = 0; bus.r0_lock = 0; bus.r0_valid = 1;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(posedge nub_clkn);
            if (bus.mst_valid) seen = 1;
        end
        checks++; if (seen !== 1'b1) begin failures++; $display("FAIL mid_issue_reached got=%b required=1", seen); end
        #2 nub_resetn = 0;
        #1;
        checks++; if (bus.mst_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b required=0", bus.mst_valid); end
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL mid_rst_state got=%0d required=%0d", state_dbg, S_IDLE); end
        bus.r0_valid = 0;
        repeat (3) begin
            @(posedge nub_clkn);
            if (bus.r0_ready || bus.r1_ready) rdy++;
        end
        checks++; if (rdy !== 0) begin failures++; $display("FAIL mid_rst_ready got=%0d required=0", rdy); end
        nub_resetn = 1; core_en = 1; core_lat = 1;
        exp_push(1, 0, 0, 32'h0000_0200 ^ K);
        exp_push(1, 0, 1, 32'h0000_0300 ^ K);
        bus.r0_addr = 32'h0000_0200; bus.r1_addr = 32'h0000_0300;
        bus.r1_wstrb = 0; bus.r1_lock = 0;
        bus.r0_valid = 1; bus.r1_valid = 1;
        for (int c = 0; c < 20; c++) begin
            @(posedge nub_clkn);
            if (bus.mst_valid && first_gnt < 0) first_gnt = int'(bus.gnt);
            if (bus.r0_ready) bus.r0_valid = 0;
            if (bus.r1_ready) bus.r1_valid = 0;
        end
        checks++; if (first_gnt !== 0) begin failures++; $display("FAIL post_rst_first_gnt got=%0d required=0", first_gnt); end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_timeout();
        test_ready_at_timeout();
        test_reset_mid_issue();
        repeat (3) @(posedge nub_clkn);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
